if_id_decode_stage: RTL and testbench
=====================================

IF_ID_DECODE_STAGE -- requirements
Module: if_id_decode_stage

Interface
REQ-001 SHALL define parameter RF_DEPTH, default 32, number of 32-bit architectural registers (index width 5).
REQ-002 SHALL define parameter SEXT_IMM, default 1, 1 = sign-extend imm16, 0 = zero-extend.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 reset  in  1  asynchronous, active-low; clock clk.
REQ-005 instr_in  in  32  instruction word from fetch stage.
REQ-006 pc_in  in  32  PC of instr_in.
REQ-007 instr_valid  in  1  instr_in/pc_in qualify this cycle.
REQ-008 flush  in  1  squash the IF/ID contents (taken branch/jump resolved downstream).
REQ-009 ex_mem_read, ex_rd  in  1, 5  load currently in EX and its destination.
REQ-010 wb_we, wb_rd, wb_data  in  1, 5, 32  register-file write port.
REQ-011 stall  out  1  combinational; holds fetch PC and IF/ID register.
REQ-012 id_valid  out  1  ID/EX outputs carry a real instruction.
REQ-013 id_pc, id_rs_data, id_rt_data, id_imm  out  32 each  registered operands, immediate.
REQ-014 id_rs, id_rt, id_rd  out  5 each  register indices (id_rd = write target after RegDst selection).
REQ-015 id_funct, id_reg_write, id_mem_read, id_mem_write, id_branch, id_jump, id_alu_src, id_illegal  out  6,1,1,1,1,1,1,1  decoded controls.

Function
REQ-016 IF/ID register SHALL load instr_in/pc_in and set ifid_valid=instr_valid on a rising edge when stall=0 and flush=0.
REQ-017 flush=1 SHALL clear ifid_valid at the next edge regardless of stall (flush wins).
REQ-018 stall=1 SHALL hold the IF/ID register unchanged.
REQ-019 Decode SHALL act on the IF/ID contents; the ID/EX register SHALL update every edge, giving 2-cycle latency from instr_in to id_* outputs.
REQ-020 Opcodes: 0x00 R-type (reg_write, rd=instr[15:11]); 0x08 addi (reg_write, alu_src, rd=rt); 0x23 lw (reg_write, mem_read, alu_src, rd=rt); 0x2B sw (mem_write, alu_src); 0x04 beq (branch); 0x02 j (jump).
REQ-021 Any other opcode SHALL produce id_illegal=1 with all other controls 0 and id_valid=1.
REQ-022 id_imm SHALL be imm16 extended per SEXT_IMM; for j, id_imm SHALL be {pc[31:28], instr[25:0], 2'b00} computed from IF/ID pc+4.
REQ-023 Register file: RF_DEPTH x 32, write on rising edge when wb_we=1 and wb_rd!=0; register 0 SHALL always read 0.
REQ-024 Same-cycle write/read of same nonzero index SHALL return wb_data (write-through bypass).
REQ-025 Load-use hazard: stall=1 when ifid_valid and ex_mem_read and ex_rd!=0 and (ex_rd==rs or (ex_rd==rt and opcode uses rt: R-type, sw, beq)).
REQ-026 Hazard FSM: RUN -> HOLD on hazard; HOLD -> RUN next cycle (ex_rd has advanced); stall SHALL never assert more than one consecutive cycle per instruction.
REQ-027 During a stall cycle the ID/EX register SHALL load a bubble: id_valid=0, all control outputs 0.
REQ-028 flush and hazard in same cycle: stall SHALL be 0, ID/EX gets a bubble, IF/ID cleared.
REQ-029 ifid_valid=0 SHALL yield a bubble in ID/EX and stall=0.

Reset
REQ-030 reset=0 SHALL asynchronously clear ifid_valid, all ID/EX outputs to 0, FSM to RUN; stall SHALL read 0.
REQ-031 Register file contents SHALL reset to 0.
REQ-032 Reset asserted mid-stall SHALL abandon HOLD; first instruction after release SHALL follow REQ-019 latency.

Verification
REQ-033 Reset release, instr_in=0x20080005 (addi r8,r0,5) valid -> two edges later id_valid=1, id_reg_write=1, id_alu_src=1, id_rd=8, id_imm=5.
REQ-034 wb write r9=0xDEADBEEF same cycle decode reads rs=9 -> id_rs_data=0xDEADBEEF; write r0=0x1234 -> reads 0.
REQ-035 ex_mem_read=1, ex_rd=8, IF/ID holds add r10,r8,r9 -> stall=1 one cycle, ID/EX bubble, then add issues with id_valid=1.
REQ-036 flush=1 with valid IF/ID and simultaneous hazard -> stall=0, next edge id_valid=0, IF/ID invalid.
REQ-037 instr_in=0xFC000000 -> id_illegal=1, id_reg_write=id_mem_write=0; addi 0x2008FFFF -> id_imm=0xFFFFFFFF (SEXT_IMM=1).
REQ-038 reset driven low during HOLD -> all outputs 0 immediately, stall=0, no residual bubble after release.

Source files
------------

// File: rtl/if_id_decode_stage_if.sv
// Fetch/decode/execute handshake bundle for the IF/ID + decode stage.
// The master side drives fetch, hazard and write-back inputs; the slave is the stage itself.
interface if_id_decode_stage_if;
   logic [31:0] instr_in;
   logic [31:0] pc_in;
   logic        instr_valid;
   logic        flush;
   logic        ex_mem_read;
   logic [4:0]  ex_rd;
   logic        wb_we;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;

   logic        stall;
   logic        id_valid;
   logic [31:0] id_pc;
   logic [31:0] id_rs_data;
   logic [31:0] id_rt_data;
   logic [31:0] id_imm;
   logic [4:0]  id_rs;
   logic [4:0]  id_rt;
   logic [4:0]  id_rd;
   logic [5:0]  id_funct;
   logic        id_reg_write;
   logic        id_mem_read;
   logic        id_mem_write;
   logic        id_branch;
   logic        id_jump;
   logic        id_alu_src;
   logic        id_illegal;

   modport master (
      output instr_in, pc_in, instr_valid, flush, ex_mem_read, ex_rd,
             wb_we, wb_rd, wb_data,
      input  stall, id_valid, id_pc, id_rs_data, id_rt_data, id_imm,
             id_rs, id_rt, id_rd, id_funct, id_reg_write, id_mem_read,
             id_mem_write, id_branch, id_jump, id_alu_src, id_illegal
   );

   modport slave (
      input  instr_in, pc_in, instr_valid, flush, ex_mem_read, ex_rd,
             wb_we, wb_rd, wb_data,
      output stall, id_valid, id_pc, id_rs_data, id_rt_data, id_imm,
             id_rs, id_rt, id_rd, id_funct, id_reg_write, id_mem_read,
             id_mem_write, id_branch, id_jump, id_alu_src, id_illegal
   );
endinterface

// File: rtl/if_id_decode_stage.sv
// IF/ID pipeline register, register file with write-through, load-use hazard
// detection and the registered ID/EX decode outputs (2-cycle instr -> id_* latency).
module if_id_decode_stage #(
   parameter int RF_DEPTH = 32,
   parameter bit SEXT_IMM = 1'b1
) (
   input  logic clk,
   input  logic reset,
   if_id_decode_stage_if.slave bus
);

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_J     = 6'h02;

   localparam logic [0:0] ST_RUN  = 1'b0;
   localparam logic [0:0] ST_HOLD = 1'b1;

   localparam logic [5:0] RF_LIM = 6'(RF_DEPTH);

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [31:0] rs_data;
      logic [31:0] rt_data;
      logic [31:0] imm;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
      logic [5:0]  funct;
      logic        reg_write;
      logic        mem_read;
      logic        mem_write;
      logic        branch;
      logic        jump;
      logic        alu_src;
      logic        illegal;
   } idex_t;

   logic        ifid_valid_q;
   logic [31:0] ifid_instr_q;
   logic [31:0] ifid_pc_q;
   logic [0:0]  state_q, state_d;
   idex_t       idex_q, idex_d;
   logic [31:0] rf_q [RF_DEPTH];

   logic [5:0]  opc;
   logic [4:0]  rs, rt;
   logic [31:0] rs_data, rt_data;
   logic [31:0] imm_ext;
   logic [3:0]  pc4_hi;
   logic        uses_rt, hazard, stall;
   idex_t       dec;

   assign opc = ifid_instr_q[31:26];
   assign rs  = ifid_instr_q[25:21];
   assign rt  = ifid_instr_q[20:16];

   // Only the top nibble of pc+4 is needed; it carries when pc[27:2] is all ones.
   assign pc4_hi  = ifid_pc_q[31:28] + {3'd0, &ifid_pc_q[27:2]};
   assign imm_ext = SEXT_IMM ? {{16{ifid_instr_q[15]}}, ifid_instr_q[15:0]}
                             : {16'd0, ifid_instr_q[15:0]};

   always_comb begin
      rs_data = '0;
      if (rs != 5'd0 && {1'b0, rs} < RF_LIM) rs_data = rf_q[rs];
      if (bus.wb_we && rs != 5'd0 && bus.wb_rd == rs) rs_data = bus.wb_data;
   end

   always_comb begin
      rt_data = '0;
      if (rt != 5'd0 && {1'b0, rt} < RF_LIM) rt_data = rf_q[rt];
      if (bus.wb_we && rt != 5'd0 && bus.wb_rd == rt) rt_data = bus.wb_data;
   end

   // In HOLD the load has moved past EX, so the same compare must not stall again.
   always_comb begin
      uses_rt = (opc == OP_RTYPE) || (opc == OP_SW) || (opc == OP_BEQ);
      hazard  = ifid_valid_q && bus.ex_mem_read && bus.ex_rd != 5'd0 &&
                (bus.ex_rd == rs || (uses_rt && bus.ex_rd == rt));
      stall   = (state_q == ST_RUN) && hazard && !bus.flush;
      state_d = stall ? ST_HOLD : ST_RUN;
   end

   always_comb begin
      dec         = '0;
      dec.valid   = 1'b1;
      dec.pc      = ifid_pc_q;
      dec.rs      = rs;
      dec.rt      = rt;
      dec.rs_data = rs_data;
      dec.rt_data = rt_data;
      dec.imm     = imm_ext;
      case (opc)
         OP_RTYPE: begin
            dec.reg_write = 1'b1;
            dec.rd        = ifid_instr_q[15:11];
            dec.funct     = ifid_instr_q[5:0];
         end
         OP_ADDI: begin
            dec.reg_write = 1'b1;
            dec.alu_src   = 1'b1;
            dec.rd        = rt;
         end
         OP_LW: begin
            dec.reg_write = 1'b1;
            dec.mem_read  = 1'b1;
            dec.alu_src   = 1'b1;
            dec.rd        = rt;
         end
         OP_SW: begin
            dec.mem_write = 1'b1;
            dec.alu_src   = 1'b1;
         end
         OP_BEQ:  dec.branch = 1'b1;
         OP_J: begin
            dec.jump = 1'b1;
            dec.imm  = {pc4_hi, ifid_instr_q[25:0], 2'b00};
         end
         default: dec.illegal = 1'b1;
      endcase
      idex_d = (ifid_valid_q && !stall && !bus.flush) ? dec : '0;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ifid_valid_q <= 1'b0;
         ifid_instr_q <= '0;
         ifid_pc_q    <= '0;
         state_q      <= ST_RUN;
         idex_q       <= '0;
      end else begin
         state_q <= state_d;
         idex_q  <= idex_d;
         if (bus.flush) begin
            ifid_valid_q <= 1'b0;
         end else if (!stall) begin
            ifid_valid_q <= bus.instr_valid;
            ifid_instr_q <= bus.instr_in;
            ifid_pc_q    <= bus.pc_in;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < RF_DEPTH; i++) rf_q[i] <= '0;
      end else if (bus.wb_we && bus.wb_rd != 5'd0 && {1'b0, bus.wb_rd} < RF_LIM) begin
         rf_q[bus.wb_rd] <= bus.wb_data;
      end
   end

   assign bus.stall        = stall;
   assign bus.id_valid     = idex_q.valid;
   assign bus.id_pc        = idex_q.pc;
   assign bus.id_rs_data   = idex_q.rs_data;
   assign bus.id_rt_data   = idex_q.rt_data;
   assign bus.id_imm       = idex_q.imm;
   assign bus.id_rs        = idex_q.rs;
   assign bus.id_rt        = idex_q.rt;
   assign bus.id_rd        = idex_q.rd;
   assign bus.id_funct     = idex_q.funct;
   assign bus.id_reg_write = idex_q.reg_write;
   assign bus.id_mem_read  = idex_q.mem_read;
   assign bus.id_mem_write = idex_q.mem_write;
   assign bus.id_branch    = idex_q.branch;
   assign bus.id_jump      = idex_q.jump;
   assign bus.id_alu_src   = idex_q.alu_src;
   assign bus.id_illegal   = idex_q.illegal;

endmodule

// File: tb/tb_if_id_decode_stage.sv
// Directed and random stimulus for if_id_decode_stage against a cycle-level
// reference model of the fetch/decode behaviour.
module tb_if_id_decode_stage;

   logic clk;
   logic reset;
   if_id_decode_stage_if bus ();

   if_id_decode_stage #(.RF_DEPTH(32), .SEXT_IMM(1'b1)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc, rsd, rtd, imm;
      logic [4:0]  rs, rt, rd;
      logic [5:0]  funct;
      logic        rw, mr, mw, br, jp, as, il;
   } exp_t;

   int          n_chk, n_err;
   logic        m_ifv, m_held;
   logic [31:0] m_ifi, m_ifp;
   logic [31:0] m_regs [32];
   exp_t        m_exp;
   logic [31:0] fpc;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [31:0] rf_rd(input logic [4:0] idx);
      if (idx == 5'd0) return 32'd0;
      if (bus.wb_we && bus.wb_rd == idx) return bus.wb_data;
      return m_regs[idx];
   endfunction

   // Decode table written from the opcode list: each row says which controls are on.
   function automatic exp_t model_decode(input logic [31:0] ins, input logic [31:0] pc,
                                         input logic [31:0] rsd, input logic [31:0] rtd);
      exp_t        e;
      logic [31:0] nxt;
      e = '0;
      e.valid = 1'b1;
      e.pc = pc;
      e.rs = ins[25:21];
      e.rt = ins[20:16];
      e.rsd = rsd;
      e.rtd = rtd;
      e.imm = 32'($signed(ins[15:0]));
      case (ins[31:26])
         6'h00: begin e.rw = 1; e.rd = ins[15:11]; e.funct = ins[5:0]; end
         6'h08: begin e.rw = 1; e.as = 1; e.rd = ins[20:16]; end
         6'h23: begin e.rw = 1; e.mr = 1; e.as = 1; e.rd = ins[20:16]; end
         6'h2B: begin e.mw = 1; e.as = 1; end
         6'h04: e.br = 1;
         6'h02: begin
            e.jp = 1;
            nxt = pc + 32'd4;
            e.imm = {nxt[31:28], ins[25:0], 2'b00};
         end
         default: e.il = 1;
      endcase
      return e;
   endfunction

   task automatic chk_out(input exp_t e);
      chk("id_valid", bus.id_valid, e.valid);
      chk("id_pc", bus.id_pc, e.pc);
      chk("id_rs_data", bus.id_rs_data, e.rsd);
      chk("id_rt_data", bus.id_rt_data, e.rtd);
      chk("id_imm", bus.id_imm, e.imm);
      chk("id_rs", bus.id_rs, e.rs);
      chk("id_rt", bus.id_rt, e.rt);
      chk("id_rd", bus.id_rd, e.rd);
      chk("id_funct", bus.id_funct, e.funct);
      chk("id_reg_write", bus.id_reg_write, e.rw);
      chk("id_mem_read", bus.id_mem_read, e.mr);
      chk("id_mem_write", bus.id_mem_write, e.mw);
      chk("id_branch", bus.id_branch, e.br);
      chk("id_jump", bus.id_jump, e.jp);
      chk("id_alu_src", bus.id_alu_src, e.as);
      chk("id_illegal", bus.id_illegal, e.il);
   endtask

   task automatic model_reset();
      m_ifv = 0; m_held = 0; m_ifi = '0; m_ifp = '0; m_exp = '0;
      for (int i = 0; i < 32; i++) m_regs[i] = '0;
   endtask

   task automatic drv(input logic [31:0] ins, input logic v, input logic fl,
                      input logic exmr, input logic [4:0] exrd,
                      input logic we, input logic [4:0] wrd, input logic [31:0] wd);
      bus.instr_in = ins; bus.pc_in = fpc; bus.instr_valid = v; bus.flush = fl;
      bus.ex_mem_read = exmr; bus.ex_rd = exrd;
      bus.wb_we = we; bus.wb_rd = wrd; bus.wb_data = wd;
      fpc = fpc + 32'd4;
   endtask

   // One clock: check stall against the model, advance the model, check ID/EX after the edge.
   task automatic step();
      logic       hz, st, urt;
      logic [4:0] frs, frt;
      exp_t       nx;
      #1;
      frs = m_ifi[25:21];
      frt = m_ifi[20:16];
      urt = (m_ifi[31:26] == 6'h00) || (m_ifi[31:26] == 6'h2B) || (m_ifi[31:26] == 6'h04);
      hz  = m_ifv && bus.ex_mem_read && bus.ex_rd != 0 &&
            (bus.ex_rd == frs || (urt && bus.ex_rd == frt));
      st  = hz && !m_held && !bus.flush;
      chk("stall", bus.stall, st);
      if (m_ifv && !st && !bus.flush) nx = model_decode(m_ifi, m_ifp, rf_rd(frs), rf_rd(frt));
      else nx = '0;
      if (bus.flush) m_ifv = 0;
      else if (!st) begin
         m_ifv = bus.instr_valid; m_ifi = bus.instr_in; m_ifp = bus.pc_in;
      end
      if (bus.wb_we && bus.wb_rd != 0) m_regs[bus.wb_rd] = bus.wb_data;
      m_held = st;
      m_exp = nx;
      @(posedge clk);
      #1;
      chk_out(m_exp);
   endtask

   function automatic logic [31:0] rnd_instr();
      logic [5:0]  op;
      logic [15:0] lo;
      case ($urandom_range(0, 6))
         0: op = 6'h00;
         1: op = 6'h08;
         2: op = 6'h23;
         3: op = 6'h2B;
         4: op = 6'h04;
         5: op = 6'h02;
         default: op = 6'($urandom);
      endcase
      lo = 16'($urandom);
      if (op == 6'h00) lo[15:11] = 5'($urandom_range(0, 11));
      return {op, 5'($urandom_range(0, 11)), 5'($urandom_range(0, 11)), lo};
   endfunction

   localparam logic [31:0] ADD_R10 = 32'h01095020;  // add r10,r8,r9

   initial begin
      logic [4:0] hrd;
      n_chk = 0; n_err = 0; fpc = 32'h0000_1000;
      model_reset();
      reset = 1'b0;
      drv(32'h0, 1'b1, 1'b0, 1'b1, 5'd3, 1'b0, 5'd0, 32'd0);
      #12;
      chk("rst_stall", bus.stall, 1'b0);
      chk_out('0);
      reset = 1'b1;

      // addi r8,r0,5 -> visible two edges later
      drv(32'h20080005, 1, 0, 0, 0, 0, 0, 0); step();
      drv(32'h0, 0, 0, 0, 0, 0, 0, 0); step();
      chk("addi_valid", bus.id_valid, 1); chk("addi_rw", bus.id_reg_write, 1);
      chk("addi_as", bus.id_alu_src, 1); chk("addi_rd", bus.id_rd, 8);
      chk("addi_imm", bus.id_imm, 5);

      // write-through bypass, and r0 stays zero
      drv(32'h01200820, 1, 0, 0, 0, 0, 0, 0); step();
      drv(32'h00000820, 1, 0, 0, 0, 1, 9, 32'hDEADBEEF); step();
      chk("bypass_r9", bus.id_rs_data, 32'hDEADBEEF);
      drv(32'h0, 0, 0, 0, 0, 1, 0, 32'h1234); step();
      chk("r0_zero", bus.id_rs_data, 32'd0);

      // load-use: one stall, one bubble, then issue even though hazard inputs persist
      drv(ADD_R10, 1, 0, 0, 0, 0, 0, 0); step();
      drv(32'h0, 0, 0, 1, 8, 0, 0, 0); #1; chk("lu_stall", bus.stall, 1); step();
      chk("lu_bubble", bus.id_valid, 0);
      drv(32'h0, 0, 0, 1, 8, 0, 0, 0); #1; chk("lu_release", bus.stall, 0); step();
      chk("lu_issue", bus.id_valid, 1); chk("lu_rd", bus.id_rd, 10);

      // flush beats hazard
      drv(ADD_R10, 1, 0, 0, 0, 0, 0, 0); step();
      drv(32'h20080005, 1, 1, 1, 8, 0, 0, 0); #1; chk("fl_stall", bus.stall, 0); step();
      chk("fl_bubble", bus.id_valid, 0);
      drv(32'h0, 0, 0, 0, 0, 0, 0, 0); step();
      chk("fl_ifid_inv", bus.id_valid, 0);

      // illegal opcode and sign extension
      drv(32'hFC000000, 1, 0, 0, 0, 0, 0, 0); step();
      drv(32'h2008FFFF, 1, 0, 0, 0, 0, 0, 0); step();
      chk("ill", bus.id_illegal, 1); chk("ill_rw", bus.id_reg_write, 0);
      chk("ill_mw", bus.id_mem_write, 0);
      drv(32'h0, 0, 0, 0, 0, 0, 0, 0); step();
      chk("sext_imm", bus.id_imm, 32'hFFFFFFFF);

      // reset during HOLD
      drv(ADD_R10, 1, 0, 0, 0, 0, 0, 0); step();
      drv(32'h0, 0, 0, 1, 9, 0, 0, 0); step();
      reset = 1'b0; model_reset(); #1;
      chk("rh_stall", bus.stall, 0); chk_out('0);
      #2 reset = 1'b1;
      drv(32'h20080005, 1, 0, 1, 8, 0, 0, 0); step();
      chk("rh_lat1", bus.id_valid, 0);
      drv(32'h0, 0, 0, 0, 0, 0, 0, 0); step();
      chk("rh_lat2", bus.id_valid, 1);

      // random traffic, PC crossing a 256MB boundary to exercise the jump target
      fpc = 32'h0FFF_FF00;
      for (int c = 0; c < 400; c++) begin
         hrd = ($urandom_range(0, 1) == 0) ? m_ifi[25:21 - 0] : 5'($urandom_range(0, 11));
         if ($urandom_range(0, 3) == 0) hrd = m_ifi[20:16];
         drv(rnd_instr(), ($urandom_range(0, 6) != 0), ($urandom_range(0, 11) == 0),
             ($urandom_range(0, 4) < 2), hrd,
             ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 11)), $urandom);
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
